// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and enable.
module multicycle_ctrl #(
   parameter int STATEW = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        op,
   input  logic [2:0]        funct3,
   input  logic              funct7b5,
   input  logic              zero,
   output logic              pcwrite,
   output logic              adrsrc,
   output logic              memwrite,
   output logic              irwrite,
   output logic [1:0]        resultsrc,
   output logic [2:0]        alucontrol,
   output logic [1:0]        alusrca,
   output logic [1:0]        alusrcb,
   output logic [1:0]        immsrc,
   output logic              regwrite,
   output logic [STATEW-1:0] state
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECUTER = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_EXECUTEI = 4'd8;
   localparam logic [3:0] S_JAL      = 4'd9;
   localparam logic [3:0] S_BEQ      = 4'd10;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic       w_pcupdate;
   logic       w_branch;
   logic       w_adrsrc;
   logic       w_memwrite;
   logic       w_irwrite;
   logic [1:0] w_resultsrc;
   logic [2:0] w_alucontrol;
   logic [1:0] w_alusrca;
   logic [1:0] w_alusrcb;
   logic       w_regwrite;

   // Unsupported funct3 values fall back to add without trapping.
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic op5,
                                             input logic f7b5);
      logic [2:0] res;
      case (f3)
         3'b000:  res = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
         3'b010:  res = ALU_SLT;
         3'b110:  res = ALU_OR;
         3'b111:  res = ALU_AND;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; unused encodings return to FETCH
   always_comb begin
      w_next = S_FETCH;
      case (r_state)
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_R:         w_next = S_EXECUTER;
               OP_I:         w_next = S_EXECUTEI;
               OP_JAL:       w_next = S_JAL;
               OP_BEQ:       w_next = S_BEQ;
               default:      w_next = S_FETCH;
            endcase
         end
         S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  w_next = S_MEMWB;
         S_EXECUTER: w_next = S_ALUWB;
         S_EXECUTEI: w_next = S_ALUWB;
         S_JAL:      w_next = S_ALUWB;
         default:    w_next = S_FETCH;
      endcase
   end

   // Moore decode of the datapath controls
   always_comb begin
      w_pcupdate   = 1'b0;
      w_branch     = 1'b0;
      w_adrsrc     = 1'b0;
      w_memwrite   = 1'b0;
      w_irwrite    = 1'b0;
      w_resultsrc  = 2'b00;
      w_alucontrol = ALU_ADD;
      w_alusrca    = 2'b00;
      w_alusrcb    = 2'b00;
      w_regwrite   = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_irwrite   = 1'b1;
            w_alusrcb   = 2'b10;
            w_resultsrc = 2'b10;
            w_pcupdate  = 1'b1;
         end
         S_DECODE: begin
            w_alusrca = 2'b01;
            w_alusrcb = 2'b01;
         end
         S_MEMADR: begin
            w_alusrca = 2'b10;
            w_alusrcb = 2'b01;
         end
         S_MEMREAD: begin
            w_adrsrc = 1'b1;
         end
         S_MEMWB: begin
            w_resultsrc = 2'b01;
            w_regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            w_adrsrc   = 1'b1;
            w_memwrite = 1'b1;
         end
         S_EXECUTER: begin
            w_alusrca    = 2'b10;
            w_alucontrol = alu_decode(funct3, op[5], funct7b5);
         end
         S_EXECUTEI: begin
            w_alusrca    = 2'b10;
            w_alusrcb    = 2'b01;
            w_alucontrol = alu_decode(funct3, op[5], funct7b5);
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
         end
         S_JAL: begin
            w_alusrca  = 2'b01;
            w_alusrcb  = 2'b10;
            w_pcupdate = 1'b1;
         end
         S_BEQ: begin
            w_alusrca    = 2'b10;
            w_alucontrol = ALU_SUB;
            w_branch     = 1'b1;
         end
         default: begin
            w_pcupdate = 1'b0;
         end
      endcase
   end

   // Write enables are suppressed while reset is held; selects still show FETCH
   always_comb begin
      if (reset) begin
         pcwrite  = 1'b0;
         memwrite = 1'b0;
         irwrite  = 1'b0;
         regwrite = 1'b0;
      end else begin
         pcwrite  = w_pcupdate | (w_branch & zero);
         memwrite = w_memwrite;
         irwrite  = w_irwrite;
         regwrite = w_regwrite;
      end
   end

   // Immediate format follows the opcode in every state
   always_comb begin
      case (op)
         OP_SW:   immsrc = 2'b01;
         OP_BEQ:  immsrc = 2'b10;
         OP_JAL:  immsrc = 2'b11;
         default: immsrc = 2'b00;
      endcase
   end

   assign adrsrc     = w_adrsrc;
   assign resultsrc  = w_resultsrc;
   assign alucontrol = w_alucontrol;
   assign alusrca    = w_alusrca;
   assign alusrcb    = w_alusrcb;
   assign state      = STATEW'(r_state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_ctrl;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BEQ = 7'b1100011;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.STATEW(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
      .irwrite(irwrite), .resultsrc(resultsrc), .alucontrol(alucontrol),
      .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc), .regwrite(regwrite),
      .state(state)
   );

   function automatic logic [1:0] ref_imm(input logic [6:0] o);
      if (o == SW) return 2'b01;
      else if (o == BEQ) return 2'b10;
      else if (o == JAL) return 2'b11;
      else return 2'b00;
   endfunction

   // ALU operation the instruction semantically asks for
   function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7);
      if (f3 == 3'd0) return (o == RT && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'd2) return 3'b101;
      else if (f3 == 3'd6) return 3'b011;
      else if (f3 == 3'd7) return 3'b010;
      else return 3'b000;
   endfunction

   // Runs one instruction from FETCH back to the next FETCH and checks it.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input string tag);
      int seq[$];
      int cnt_rw = 0;
      int cnt_mw = 0;
      int cnt_pw = 0;
      int cnt_ir = 0;
      int exp_rw;
      int exp_pw;
      logic [3:0] es;
      case (o)
         LW:      seq = '{0, 1, 2, 3, 4};
         SW:      seq = '{0, 1, 2, 5};
         RT:      seq = '{0, 1, 6, 7};
         IT:      seq = '{0, 1, 8, 7};
         JAL:     seq = '{0, 1, 9, 7};
         BEQ:     seq = '{0, 1, 10};
         default: seq = '{0, 1};
      endcase
      seq.push_back(0);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      for (int i = 0; i < seq.size(); i++) begin
         #1;
         es = seq[i][3:0];
         n_cmp++;
         if (state !== es) begin
            n_bad++;
            $display("FAIL %s state[%0d]: got %0d want %0d", tag, i, state, es);
         end
         n_cmp++;
         if (immsrc !== ref_imm(o)) begin
            n_bad++;
            $display("FAIL %s immsrc: got %b want %b", tag, immsrc, ref_imm(o));
         end
         if (i < seq.size() - 1) begin
            cnt_rw += int'(regwrite);
            cnt_mw += int'(memwrite);
            cnt_pw += int'(pcwrite);
            cnt_ir += int'(irwrite);
            if (regwrite === 1'b1) begin
               n_cmp++;
               if (resultsrc !== ((o == LW) ? 2'b01 : 2'b00)) begin
                  n_bad++;
                  $display("FAIL %s wb resultsrc: got %b", tag, resultsrc);
               end
            end
            if (memwrite === 1'b1) begin
               n_cmp++;
               if (adrsrc !== 1'b1) begin
                  n_bad++;
                  $display("FAIL %s sw adrsrc: got %b want 1", tag, adrsrc);
               end
            end
            if (es == 4'd6 || es == 4'd8) begin
               n_cmp++;
               if (alucontrol !== ref_alu(o, f3, f7) || alusrca !== 2'b10 ||
                   alusrcb !== ((es == 4'd8) ? 2'b01 : 2'b00)) begin
                  n_bad++;
                  $display("FAIL %s exec: alu=%b srca=%b srcb=%b want alu=%b", tag,
                           alucontrol, alusrca, alusrcb, ref_alu(o, f3, f7));
               end
            end
            if (es == 4'd10) begin
               n_cmp++;
               if (alucontrol !== 3'b001) begin
                  n_bad++;
                  $display("FAIL %s beq alu: got %b want 001", tag, alucontrol);
               end
            end
            if (es == 4'd0) begin
               n_cmp++;
               if (alusrcb !== 2'b10 || resultsrc !== 2'b10 || adrsrc !== 1'b0) begin
                  n_bad++;
                  $display("FAIL %s fetch sel: srcb=%b res=%b adr=%b", tag, alusrcb,
                           resultsrc, adrsrc);
               end
            end
            @(negedge clk);
         end
      end
      exp_rw = (o == LW || o == RT || o == IT || o == JAL) ? 1 : 0;
      exp_pw = 1 + ((o == JAL) ? 1 : 0) + ((o == BEQ && z) ? 1 : 0);
      n_cmp++;
      if (cnt_rw != exp_rw) begin
         n_bad++;
         $display("FAIL %s regwrite count: got %0d want %0d", tag, cnt_rw, exp_rw);
      end
      n_cmp++;
      if (cnt_mw != ((o == SW) ? 1 : 0)) begin
         n_bad++;
         $display("FAIL %s memwrite count: got %0d want %0d", tag, cnt_mw, (o == SW) ? 1 : 0);
      end
      n_cmp++;
      if (cnt_pw != exp_pw) begin
         n_bad++;
         $display("FAIL %s pcwrite count: got %0d want %0d", tag, cnt_pw, exp_pw);
      end
      n_cmp++;
      if (cnt_ir != 1) begin
         n_bad++;
         $display("FAIL %s irwrite count: got %0d want 1", tag, cnt_ir);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; op = RT;
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (state !== 4'd0 || pcwrite !== 1'b0 || irwrite !== 1'b0 ||
          memwrite !== 1'b0 || regwrite !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hold: state=%0d pw=%b ir=%b mw=%b rw=%b want 0 all", state,
                  pcwrite, irwrite, memwrite, regwrite);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (irwrite !== 1'b1 || pcwrite !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release: ir=%b pw=%b want 1 1", irwrite, pcwrite);
      end
   endtask

   task automatic test_lw();
      run_instr(LW, 3'b010, 1'b0, 1'b0, "lw");
   endtask

   task automatic test_sw();
      run_instr(SW, 3'b010, 1'b0, 1'b1, "sw");
   endtask

   task automatic test_alu_decode();
      run_instr(RT, 3'b000, 1'b1, 1'b0, "sub");
      run_instr(RT, 3'b000, 1'b0, 1'b0, "add");
      run_instr(IT, 3'b000, 1'b1, 1'b0, "addi");
      run_instr(RT, 3'b111, 1'b0, 1'b0, "and");
      run_instr(IT, 3'b110, 1'b0, 1'b0, "ori");
      run_instr(RT, 3'b010, 1'b0, 1'b0, "slt");
      run_instr(IT, 3'b001, 1'b1, 1'b0, "unsup");
   endtask

   task automatic test_beq();
      run_instr(BEQ, 3'b000, 1'b0, 1'b1, "beq_taken");
      run_instr(BEQ, 3'b000, 1'b0, 1'b0, "beq_not");
   endtask

   task automatic test_jal_illegal();
      run_instr(JAL, 3'b000, 1'b0, 1'b0, "jal");
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal");
   endtask

   // Reset in MEMREAD and in MEMWB must abandon the load without a write.
   task automatic test_reset_mid();
      for (int k = 3; k <= 4; k++) begin
         op = LW; funct3 = 3'b010;
         for (int c = 0; c < k; c++) @(negedge clk);
         n_cmp++;
         if (state !== 4'(k)) begin
            n_bad++;
            $display("FAIL rst_mid reach: got %0d want %0d", state, k);
         end
         reset = 1'b1;
         #1;
         n_cmp++;
         if (regwrite !== 1'b0 || pcwrite !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid force: rw=%b pw=%b want 0 0", regwrite, pcwrite);
         end
         @(negedge clk);
         n_cmp++;
         if (state !== 4'd0 || regwrite !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid next: state=%0d rw=%b want 0 0", state, regwrite);
         end
         reset = 1'b0;
      end
   endtask

   task automatic test_random();
      logic [6:0] o;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 6))
            0: o = LW;
            1: o = SW;
            2: o = RT;
            3: o = IT;
            4: o = JAL;
            5: o = BEQ;
            default: begin
               o = 7'($urandom_range(0, 127));
               while (o == LW || o == SW || o == RT || o == IT || o == JAL || o == BEQ)
                  o = 7'($urandom_range(0, 127));
            end
         endcase
         run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw();
      test_alu_decode();
      test_beq();
      test_jal_illegal();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I datapath. It sequences one shared ALU, one unified instruction/data memory and the immediate extender across fetch, decode, execute, memory and writeback cycles.
- Decodes op/funct3/funct7b5 from the instruction register and drives every datapath select and write enable, including the 2-bit immsrc consumed by the immediate extender.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

Parameters:
STATEW, 4, width of the state debug output.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
op  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag (valid in BEQ state)
pcwrite  out  1  PC register enable
adrsrc  out  1  memory address select: 0 = PC, 1 = Result
memwrite  out  1  data memory write enable
irwrite  out  1  instruction/oldPC register enable
resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
alusrca  out  2  00 PC, 01 OldPC, 10 RD1
alusrcb  out  2  00 RD2, 01 ImmExt, 10 constant 4
immsrc  out  2  00 I, 01 S, 10 B, 11 J
regwrite  out  1  register file write enable
state  out  STATEW  current state encoding (debug/verification)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high.
  - reset=1 at a rising edge loads state FETCH (0).
  - While reset=1, pcwrite, irwrite, memwrite and regwrite are forced to 0. Other outputs show FETCH decode.
  - Reset mid-instruction abandons that instruction. No writes occur in the reset cycle.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Encodings 11–15 are unused and go to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - op 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH (illegal op; no write issued)
  - MEMADR: lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Outputs are Moore per state. The only exception is pcwrite = pcupdate | (branch & zero).
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, add, resultsrc=10, pcupdate=1.
  - DECODE: alusrca=01, alusrcb=01, add (branch target precompute).
  - MEMADR: alusrca=10, alusrcb=01, add.
  - MEMREAD: resultsrc=00, adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1.
  - EXECUTER: alusrca=10, alusrcb=00, ALU decode.
  - EXECUTEI: alusrca=10, alusrcb=01, ALU decode.
  - ALUWB: resultsrc=00, regwrite=1.
  - JAL: alusrca=01, alusrcb=10, add, resultsrc=00, pcupdate=1.
  - BEQ: alusrca=10, alusrcb=00, sub, resultsrc=00, branch=1.
  - Every unlisted signal is 0.
- ALU decode (EXECUTER/EXECUTEI only):
  - funct3 000 -> sub if (op[5] & funct7b5), else add.
  - 010 -> slt; 110 -> or; 111 -> and.
  - Other funct3 -> add, with regwrite still asserted in ALUWB (unsupported, no trap).
- immsrc is combinational from op in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else 00
- Latency in cycles, FETCH to the next FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- No output changes combinationally on zero except pcwrite in BEQ.

Test Plan:
- Reset held 2 cycles with op=0110011 -> state=0, pcwrite=irwrite=memwrite=regwrite=0. After release, first cycle shows irwrite=1, pcwrite=1.
- lw (op=0000011, funct3=010) -> states 0,1,2,3,4,0. immsrc=00 throughout. regwrite=1 only in state 4 with resultsrc=01.
- sw (op=0100011) -> states 0,1,2,5,0. memwrite=1 only in state 5 with adrsrc=1. immsrc=01. regwrite never 1.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> alucontrol=001 in state 6. Same with funct7b5=0 -> 000. addi with funct7b5=1 (op=0010011) -> 000.
- beq (op=1100011) with zero=1 -> pcwrite=1 in state 10. With zero=0 -> pcwrite=0. Both return to 0 after 3 cycles. immsrc=10.
- jal (op=1101111) -> states 0,1,9,7,0. pcwrite=1 in state 9, regwrite=1 in state 7, immsrc=11. Illegal op 1111111 -> states 0,1,0 with no writes. Reset asserted in state 3 -> state 0 next edge with regwrite=0.
